// File: rtl/i2c_wr_master.sv
// I2C write-only master: START, {dev_addr,W}, 0..MAX_BYTES payload bytes with ACK
// checks, then STOP. A NACK in any ACK slot aborts straight to STOP and is reported.
// All line activity is phased off a free-running counter that spans one SCL period.
module i2c_wr_master #(
  parameter int unsigned CLK_DIV   = 500,
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned NB_W      = 3
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [6:0]             dev_addr_i,
  input  logic [NB_W-1:0]        num_bytes_i,
  input  logic [8*MAX_BYTES-1:0] wr_data_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   nack_o,
  output logic                   scl_o,
  inout  wire                    sda_io
);

  localparam int unsigned Q  = CLK_DIV / 4;
  localparam int unsigned CW = $clog2(CLK_DIV);

  localparam logic [CW-1:0]   CntQ    = CW'(Q);
  localparam logic [CW-1:0]   Cnt2Q   = CW'(2 * Q);
  localparam logic [CW-1:0]   Cnt3Q   = CW'(3 * Q);
  localparam logic [CW-1:0]   CntLast = CW'(CLK_DIV - 1);
  localparam logic [NB_W-1:0] MaxN    = NB_W'(MAX_BYTES);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StShift,
    StAck,
    StStop
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [NB_W-1:0]        left_q, left_d;
  logic [7:0]             tx_q, tx_d;
  logic [8*MAX_BYTES-1:0] data_q, data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   nack_q, nack_d;
  logic                   scl_q, scl_d;
  logic                   sda_low_q, sda_low_d;
  logic                   wrap;

  // Open-drain SDA: only ever pull low or release.
  assign sda_io = sda_low_q ? 1'b0 : 1'bz;

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign nack_o = nack_q;
  assign scl_o  = scl_q;

  // Next-state logic; every line change is decided against the next phase count so
  // registered SCL/SDA move on the same edge the counter reaches that phase.
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    left_d    = left_q;
    tx_d      = tx_q;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    nack_d    = nack_q;
    sda_low_d = sda_low_q;
    wrap      = (cnt_q == CntLast);
    cnt_d     = '0;
    if (busy_q) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StStart;
          busy_d    = 1'b1;
          nack_d    = 1'b0;
          cnt_d     = '0;
          bit_d     = '0;
          tx_d      = {dev_addr_i, 1'b0};
          data_d    = wr_data_i;
          left_d    = (num_bytes_i > MaxN) ? MaxN : num_bytes_i;
          sda_low_d = 1'b0;
        end
      end

      StStart: begin
        // START condition: SDA falls mid-period while SCL is held high.
        if (cnt_d == Cnt2Q) begin
          sda_low_d = 1'b1;
        end
        if (wrap) begin
          state_d = StShift;
          bit_d   = '0;
        end
      end

      StShift: begin
        if (cnt_d == CntQ) begin
          sda_low_d = ~tx_q[7];
        end
        if (wrap) begin
          if (bit_q == 3'd7) begin
            state_d = StAck;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = {tx_q[6:0], 1'b0};
          end
        end
      end

      StAck: begin
        if (cnt_d == CntQ) begin
          sda_low_d = 1'b0;
        end
        // Sample in the middle of the SCL-high half.
        if (cnt_q == Cnt3Q && sda_io) begin
          nack_d = 1'b1;
        end
        if (wrap) begin
          if (nack_q || left_q == '0) begin
            state_d = StStop;
          end else begin
            state_d = StShift;
            bit_d   = '0;
            tx_d    = data_q[7:0];
            data_d  = data_q >> 8;
            left_d  = left_q - 1'b1;
          end
        end
      end

      StStop: begin
        if (cnt_d == CntQ) begin
          sda_low_d = 1'b1;
        end
        // STOP condition: release SDA while SCL is high, then finish.
        if (cnt_d == Cnt3Q) begin
          sda_low_d = 1'b0;
          state_d   = StIdle;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          cnt_d     = '0;
        end
      end

      default: begin
        state_d   = StIdle;
        busy_d    = 1'b0;
        sda_low_d = 1'b0;
        cnt_d     = '0;
      end
    endcase

    // SCL is parked high in IDLE and START, otherwise low for the first half period.
    if (state_d == StIdle || state_d == StStart) begin
      scl_d = 1'b1;
    end else begin
      scl_d = (cnt_d >= Cnt2Q);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      left_q    <= '0;
      tx_q      <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      left_q    <= left_d;
      tx_q      <= tx_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      nack_q    <= nack_d;
      scl_q     <= scl_d;
      sda_low_q <= sda_low_d;
    end
  end

endmodule

// File: tb/tb_i2c_wr_master.sv
// Directed bench for i2c_wr_master with a bus-level slave model that decodes
// START/STOP, captures bytes on SCL rising edges and answers ACK slots.
module tb_i2c_wr_master;

  localparam int unsigned CLK_DIV   = 8;
  localparam int unsigned MAX_BYTES = 4;
  localparam int unsigned NB_W      = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  dev_addr;
  logic [2:0]  num_bytes;
  logic [31:0] wr_data;
  logic        busy, done, nack, scl;
  wire         sda;
  logic        slave_low = 1'b0;

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  i2c_wr_master #(
    .CLK_DIV  (CLK_DIV),
    .MAX_BYTES(MAX_BYTES),
    .NB_W     (NB_W)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .start_i    (start),
    .dev_addr_i (dev_addr),
    .num_bytes_i(num_bytes),
    .wr_data_i  (wr_data),
    .busy_o     (busy),
    .done_o     (done),
    .nack_o     (nack),
    .scl_o      (scl),
    .sda_io     (sda)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int t0       = 0;

  // Slave model state.
  int         nack_at   = -1;  // index of byte whose ACK slot is left high
  int         byte_idx  = 0;
  int         nbits     = 0;
  bit         in_ack    = 1'b0;
  logic [7:0] sh        = '0;
  logic [7:0] cap [8];
  int         cap_n     = 0;
  int         start_cnt = 0;
  int         stop_cnt  = 0;
  logic       scl_p     = 1'b1;
  logic       sda_p     = 1'b1;

  // Slave: watch the bus away from the DUT's active edge.
  always @(negedge clk) begin
    if (reset) begin
      nbits     = 0;
      in_ack    = 1'b0;
      slave_low = 1'b0;
    end else begin
      if (scl && scl_p && sda_p && !sda) begin
        start_cnt++;
        nbits    = 0;
        in_ack   = 1'b0;
        byte_idx = 0;
        cap_n    = 0;
      end else if (scl && scl_p && !sda_p && sda) begin
        stop_cnt++;
      end
      if (scl && !scl_p && !in_ack) begin
        sh = {sh[6:0], sda};
        nbits++;
        if (nbits == 8) begin
          if (cap_n < 8) cap[cap_n] = sh;
          cap_n++;
        end
      end
      if (!scl && scl_p) begin
        if (in_ack) begin
          in_ack    = 1'b0;
          slave_low = 1'b0;
          nbits     = 0;
        end else if (nbits == 8) begin
          in_ack    = 1'b1;
          slave_low = (byte_idx != nack_at);
          byte_idx++;
        end
      end
    end
    scl_p = scl;
    sda_p = sda;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // exp holds the expected bytes in send order, first byte in bits [7:0].
  task automatic check_cap(input string tag, input int n, input logic [39:0] exp);
    logic [39:0] e;
    e = exp;
    check({tag, "_nbytes"}, cap_n, n);
    for (int i = 0; i < n && i < cap_n; i++) begin
      check($sformatf("%s_byte%0d", tag, i), {24'b0, cap[i]}, {24'b0, e[8*i +: 8]});
    end
  endtask

  // Request a transfer; returns at the negedge after the accepting edge T0.
  task automatic kick(input logic [6:0] a, input logic [2:0] n, input logic [31:0] d,
                      input int na, input bit now);
    if (!now) @(negedge clk);
    dev_addr  = a;
    num_bytes = n;
    wr_data   = d;
    nack_at   = na;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0    = cyc;
  endtask

  // Wait for done with a cycle budget; lat = -1 on timeout. bad counts busy glitches.
  task automatic wait_done(output int lat, output int bad);
    lat = -1;
    bad = 0;
    for (int k = 0; k < 2000; k++) begin
      if (done) begin
        lat = cyc - t0;
        if (busy) bad++;
        break;
      end
      if (!busy) bad++;
      @(negedge clk);
    end
  endtask

  int lat, bad, cnt, s0;

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    dev_addr  = '0;
    num_bytes = '0;
    wr_data   = '0;
    repeat (3) @(negedge clk);
    check("rst_scl", scl, 1);
    check("rst_sda", sda, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nack", nack, 0);
    reset = 1'b0;
    @(negedge clk);

    // Two payload bytes, all ACKed.
    s0 = stop_cnt;
    kick(7'h2F, 3'd2, 32'h0000_8000, -1, 1'b0);
    check("t1_busy_t0", busy, 1);
    wait_done(lat, bad);
    check("t1_lat", lat, 230);
    check("t1_busy_win", bad, 0);
    check("t1_nack", nack, 0);
    check_cap("t1", 3, 40'h00_00_80_00_5E);
    @(negedge clk);
    check("t1_stop", stop_cnt - s0, 1);
    check("t1_done_pulse", done, 0);

    // A start while busy is dropped.
    kick(7'h2F, 3'd2, 32'h0000_8000, -1, 1'b0);
    repeat (39) @(negedge clk);
    dev_addr  = 7'h11;
    num_bytes = 3'd4;
    wr_data   = 32'hFFFF_FFFF;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bad);
    check("t4_lat", lat, 230);
    check_cap("t4", 3, 40'h00_00_80_00_5E);
    s0  = start_cnt;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check("t4_no_requeue", cnt, 0);
    check("t4_no_start", start_cnt - s0, 0);

    // Reset in the middle of a transfer.
    kick(7'h2F, 3'd2, 32'h0000_8000, -1, 1'b0);
    repeat (99) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5_scl", scl, 1);
    check("t5_sda", sda, 1);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    reset = 1'b0;
    cnt   = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("t5_quiet", cnt, 0);
    kick(7'h2F, 3'd2, 32'h0000_8000, -1, 1'b0);
    wait_done(lat, bad);
    check("t5_lat", lat, 230);
    check_cap("t5", 3, 40'h00_00_80_00_5E);

    // Address NACK aborts straight to STOP.
    kick(7'h2F, 3'd2, 32'h0000_8000, 0, 1'b0);
    wait_done(lat, bad);
    check("t2_lat", lat, 86);
    check("t2_nack", nack, 1);
    check_cap("t2", 1, 40'h00_00_00_00_5E);
    repeat (5) @(negedge clk);
    check("t2_nack_hold", nack, 1);

    // Address-only probe; nack clears on accept.
    kick(7'h2F, 3'd0, 32'h0, -1, 1'b0);
    check("t3_nack_clr", nack, 0);
    wait_done(lat, bad);
    check("t3_lat", lat, 86);
    check("t3_busy_win", bad, 0);
    check("t3_nack", nack, 0);
    check_cap("t3", 1, 40'h00_00_00_00_5E);

    // Start in the done cycle is accepted back-to-back.
    kick(7'h2F, 3'd2, 32'h0000_8000, -1, 1'b1);
    check("t6_busy", busy, 1);
    check("t6_scl", scl, 1);
    wait_done(lat, bad);
    check("t6_lat", lat, 230);
    check_cap("t6", 3, 40'h00_00_80_00_5E);

    // Byte count above MAX_BYTES is clamped.
    kick(7'h2F, 3'd7, 32'h4433_2211, -1, 1'b0);
    wait_done(lat, bad);
    check("clamp_lat", lat, 374);
    check("clamp_nack", nack, 0);
    check_cap("clamp", 5, 40'h44_33_22_11_5E);

    // NACK on a payload byte stops after that slot.
    kick(7'h2F, 3'd4, 32'h4433_2211, 2, 1'b0);
    wait_done(lat, bad);
    check("pnack_lat", lat, 230);
    check("pnack_nack", nack, 1);
    check_cap("pnack", 3, 40'h00_00_22_11_5E);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
